// File: rtl/imm_decode_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and immediate-select layout
// for the immediate-generator control stage.
package imm_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // Legal opcodes that carry no immediate and therefore select nothing
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam int SEL_I  = 0;
   localparam int SEL_S  = 1;
   localparam int SEL_SB = 2;
   localparam int SEL_U  = 3;
   localparam int SEL_UJ = 4;

   typedef logic [4:0] imm_sel_t;

   localparam imm_sel_t SEL_NONE  = 5'b00000;
   localparam imm_sel_t SEL_ILOAD = 5'b00001;

endpackage

// File: rtl/imm_decode_ctrl_if.sv
// Fetch-side and generator-side signals of the immediate control stage.
// The illegal flag exists only when ILLEGAL_DETECT_EN is defined.
interface imm_decode_ctrl_if;

   logic [31:0] in_inst;
   logic        in_valid;
   logic        in_ready;
   logic        nop;
   logic        out_ready;
   logic        out_valid;
   logic [24:0] Inst;
   logic        ILoad;
   logic        S;
   logic        SB;
   logic        U;
   logic        UJ;
`ifdef ILLEGAL_DETECT_EN
   logic        illegal;
`endif

   modport master (
      output in_inst, in_valid, nop, out_ready,
      input  in_ready, out_valid, Inst, ILoad, S, SB, U, UJ
`ifdef ILLEGAL_DETECT_EN
      , input illegal
`endif
   );

   modport slave (
      input  in_inst, in_valid, nop, out_ready,
      output in_ready, out_valid, Inst, ILoad, S, SB, U, UJ
`ifdef ILLEGAL_DETECT_EN
      , output illegal
`endif
   );

endinterface

// File: rtl/imm_decode_ctrl_opcode_decode.sv
// Combinational opcode to one-hot immediate-select decoder.
// ILLEGAL_DETECT_EN adds the illegal-opcode flag.
module imm_opcode_decode
   import imm_pkg::*;
(
   input  logic [6:0] opcode,
`ifdef ILLEGAL_DETECT_EN
   output logic       illegal,
`endif
   output imm_sel_t   sel
);

   always_comb begin
      sel = SEL_NONE;
      case (opcode)
         OPC_LOAD, OPC_OPIMM, OPC_JALR: sel[SEL_I]  = 1'b1;
         OPC_STORE:                     sel[SEL_S]  = 1'b1;
         OPC_BRANCH:                    sel[SEL_SB] = 1'b1;
         OPC_LUI, OPC_AUIPC:            sel[SEL_U]  = 1'b1;
         OPC_JAL:                       sel[SEL_UJ] = 1'b1;
         default:                       sel = SEL_NONE;
      endcase
   end

`ifdef ILLEGAL_DETECT_EN
   // Compressed encodings (low bits not 11) are never accepted here
   always_comb begin
      illegal = 1'b0;
      if (opcode[1:0] != 2'b11)
         illegal = 1'b1;
      else if (sel == SEL_NONE && opcode != OPC_OP &&
               opcode != OPC_FENCE && opcode != OPC_SYSTEM)
         illegal = 1'b1;
   end
`endif

endmodule

// File: rtl/imm_decode_ctrl.sv
// Immediate-generator control stage: valid/ready instruction capture,
// registered opcode decode, flush hold sequencing. Optional: ILLEGAL_DETECT_EN.
module imm_decode_ctrl
   import imm_pkg::*;
#(
   parameter int          FLUSH_HOLD = 1,
   parameter logic [31:0] NOP_INST   = 32'h00000013
)(
   input  logic                clk,
   input  logic                rst,
   imm_decode_ctrl_if.slave    bus
);

   localparam logic [1:0] HOLD_INIT = 2'(FLUSH_HOLD - 1);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [24:0] inst_q, inst_d;
   imm_sel_t    sel_q, sel_d;
   logic        valid_q, valid_d;
   imm_sel_t    dec_sel;
   logic        ready;
   logic        accept;
`ifdef ILLEGAL_DETECT_EN
   logic        illegal_q, illegal_d;
   logic        dec_illegal;
`endif

   imm_opcode_decode u_dec (
      .opcode  (bus.in_inst[6:0]),
`ifdef ILLEGAL_DETECT_EN
      .illegal (dec_illegal),
`endif
      .sel     (dec_sel)
   );

   assign ready  = (state_q == ST_RUN) && (!valid_q || bus.out_ready);
   // A flush in the same cycle drops the offered instruction
   assign accept = bus.in_valid && ready && !bus.nop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         cnt_q     <= 2'd0;
         inst_q    <= NOP_INST[31:7];
         sel_q     <= SEL_NONE;
         valid_q   <= 1'b0;
`ifdef ILLEGAL_DETECT_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         inst_q    <= inst_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
`ifdef ILLEGAL_DETECT_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      inst_d    = inst_q;
      sel_d     = sel_q;
      valid_d   = valid_q;
`ifdef ILLEGAL_DETECT_EN
      illegal_d = illegal_q;
`endif
      if (bus.nop) begin
         state_d   = ST_FLUSH;
         cnt_d     = HOLD_INIT;
         inst_d    = NOP_INST[31:7];
         sel_d     = SEL_ILOAD;
         valid_d   = 1'b0;
`ifdef ILLEGAL_DETECT_EN
         illegal_d = 1'b0;
`endif
      end else begin
         case (state_q)
            ST_FLUSH: begin
               if (cnt_q == 2'd0)
                  state_d = ST_RUN;
               else
                  cnt_d = cnt_q - 2'd1;
            end
            default: begin
               if (accept) begin
                  inst_d    = bus.in_inst[31:7];
                  sel_d     = dec_sel;
                  valid_d   = 1'b1;
`ifdef ILLEGAL_DETECT_EN
                  illegal_d = dec_illegal;
`endif
               end else if (valid_q && bus.out_ready) begin
                  valid_d = 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = valid_q;
   assign bus.Inst      = inst_q;
   assign bus.ILoad     = sel_q[SEL_I];
   assign bus.S         = sel_q[SEL_S];
   assign bus.SB        = sel_q[SEL_SB];
   assign bus.U         = sel_q[SEL_U];
   assign bus.UJ        = sel_q[SEL_UJ];
`ifdef ILLEGAL_DETECT_EN
   assign bus.illegal   = illegal_q;
`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed self-checking bench for imm_decode_ctrl (default parameters).
// Covers ILLEGAL_DETECT_EN checks when that macro is defined.
module tb_imm_decode_ctrl;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   localparam logic [31:0] ADDI  = 32'h00A00093;
   localparam logic [31:0] SW    = 32'h00112623;
   localparam logic [31:0] BEQ   = 32'h00208463;
   localparam logic [31:0] LUI   = 32'h123452B7;
   localparam logic [31:0] JAL   = 32'h008000EF;
   localparam logic [31:0] BADOP = 32'h0000007F;
   localparam logic [31:0] ADDR  = 32'h002081B3;
   localparam logic [31:0] CINST = 32'h00000011;

   // Expected select vectors packed as {UJ,U,SB,S,ILoad}
   localparam logic [4:0] E_NONE = 5'b00000;
   localparam logic [4:0] E_I    = 5'b00001;
   localparam logic [4:0] E_S    = 5'b00010;
   localparam logic [4:0] E_SB   = 5'b00100;
   localparam logic [4:0] E_U    = 5'b01000;
   localparam logic [4:0] E_UJ   = 5'b10000;

   imm_decode_ctrl_if bus ();

   imm_decode_ctrl #(
      .FLUSH_HOLD (1),
      .NOP_INST   (32'h00000013)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [4:0] selOut();
      return {bus.UJ, bus.U, bus.SB, bus.S, bus.ILoad};
   endfunction

   task automatic applyStimulus(input logic [31:0] inst, input logic valid,
                                input logic flush, input logic outReady);
      bus.in_inst   = inst;
      bus.in_valid  = valid;
      bus.nop       = flush;
      bus.out_ready = outReady;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_sel", 32'(selOut()), 32'(E_NONE));
      checkOutput("rst_inst", 32'(bus.Inst), 32'h0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      rst = 1'b0;

      applyStimulus(ADDI, 1'b1, 1'b0, 1'b1);
      checkOutput("addi_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      checkOutput("addi_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("addi_sel", 32'(selOut()), 32'(E_I));
      checkOutput("addi_inst", 32'(bus.Inst), 32'h0014001);

      applyStimulus(SW, 1'b1, 1'b0, 1'b1);
      checkOutput("sw_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      checkOutput("sw_sel", 32'(selOut()), 32'(E_S));
      checkOutput("sw_inst", 32'(bus.Inst), 32'h000224C);
      applyStimulus(BEQ, 1'b1, 1'b0, 1'b1);
      checkOutput("beq_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      checkOutput("beq_sel", 32'(selOut()), 32'(E_SB));
      checkOutput("beq_inst", 32'(bus.Inst), 32'h0004108);
      checkOutput("beq_out_valid", 32'(bus.out_valid), 32'd1);

      applyStimulus(LUI, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("lui_sel", 32'(selOut()), 32'(E_U));
      checkOutput("lui_inst", 32'(bus.Inst), 32'h02468A5);
      applyStimulus(ADDI, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
         checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("hold_sel", 32'(selOut()), 32'(E_U));
         checkOutput("hold_inst", 32'(bus.Inst), 32'h02468A5);
         tick();
      end
      checkOutput("hold_end_inst", 32'(bus.Inst), 32'h02468A5);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      checkOutput("drain_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("drain_sel_kept", 32'(selOut()), 32'(E_U));
      checkOutput("drain_inst_kept", 32'(bus.Inst), 32'h02468A5);

      applyStimulus(JAL, 1'b1, 1'b1, 1'b1);
      tick();
      checkOutput("nop_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("nop_sel", 32'(selOut()), 32'(E_I));
      checkOutput("nop_inst", 32'(bus.Inst), 32'h0);
      applyStimulus(JAL, 1'b1, 1'b0, 1'b1);
      checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      checkOutput("flush_done_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("jal_dropped", 32'(bus.out_valid), 32'd0);
      tick();
      checkOutput("jal_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("jal_sel", 32'(selOut()), 32'(E_UJ));
      checkOutput("jal_inst", 32'(bus.Inst), 32'h0010001);

      applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
      tick();
      checkOutput("nop2_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("restart_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      checkOutput("restart_done_in_ready", 32'(bus.in_ready), 32'd1);

      applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst_flush_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_flush_sel", 32'(selOut()), 32'(E_NONE));

      applyStimulus(LUI, 1'b1, 1'b0, 1'b1);
      tick();
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("held_out_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst_held_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_held_sel", 32'(selOut()), 32'(E_NONE));
      checkOutput("rst_held_inst", 32'(bus.Inst), 32'h0);
      checkOutput("rst_held_in_ready", 32'(bus.in_ready), 32'd1);

      applyStimulus(BADOP, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("badop_sel", 32'(selOut()), 32'(E_NONE));
      checkOutput("badop_out_valid", 32'(bus.out_valid), 32'd1);
`ifdef ILLEGAL_DETECT_EN
      checkOutput("badop_illegal", 32'(bus.illegal), 32'd1);
`endif
      applyStimulus(ADDI, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("addi2_sel", 32'(selOut()), 32'(E_I));
`ifdef ILLEGAL_DETECT_EN
      checkOutput("addi2_illegal", 32'(bus.illegal), 32'd0);
`endif
      applyStimulus(ADDR, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("rtype_sel", 32'(selOut()), 32'(E_NONE));
`ifdef ILLEGAL_DETECT_EN
      checkOutput("rtype_illegal", 32'(bus.illegal), 32'd0);
      applyStimulus(CINST, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("cinst_illegal", 32'(bus.illegal), 32'd1);
      applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
      tick();
      checkOutput("nop_clr_illegal", 32'(bus.illegal), 32'd0);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
      tick();
`else
      applyStimulus(CINST, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("cinst_sel", 32'(selOut()), 32'(E_NONE));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/imm_decode_ctrl.md
Name: imm_decode_ctrl

Overview:
Control stage in front of the immediate generator.
- Accepts fetched 32-bit instructions over a valid/ready handshake and decodes the opcode into the one-hot immediate-type selects.
- Registers instruction bits [31:7] as the 25-bit immediate field and drives the generator's inputs.
- Sequences flush (nop) and downstream stall so the generator never sees a torn or stale instruction.

Parameters:
- FLUSH_HOLD, 1: cycles in_ready stays low after a flush before new instructions are accepted (legal 1..3).
- NOP_INST, 32'h00000013: instruction loaded into the stage on flush (addi x0,x0,0).

Ports:
- clk  in  1  processor main clock
- rst  in  1  synchronous active-high reset
- in_inst  in  32  fetched instruction
- in_valid  in  1  in_inst valid
- in_ready  out  1  stage can accept in_inst this cycle
- nop  in  1  flush request; clears the stage
- out_ready  in  1  downstream (generator/execute) can consume
- out_valid  out  1  held instruction valid
- Inst  out  25  in_inst[31:7] of held instruction
- ILoad  out  1  I-type immediate select
- S  out  1  S-type select
- SB  out  1  SB-type select
- U  out  1  U-type select
- UJ  out  1  UJ-type select

Behaviour:
- Reset: synchronous active-high on clk. State=RUN, Inst=NOP_INST[31:7], out_valid=0, all selects 0, hold counter 0.
- States: RUN, FLUSH.
- Decode, registered on accept. Opcode in_inst[6:0]:
  - 0000011, 0010011, 1100111 -> ILoad
  - 0100011 -> S
  - 1100011 -> SB
  - 0110111, 0010111 -> U
  - 1101111 -> UJ
  - any other opcode -> all selects 0
  - Selects are one-hot or all-zero, never multiple.
- Latency: an instruction accepted on edge N presents Inst/selects/out_valid after edge N. The generator output follows one cycle later.
- Ready in RUN: in_ready = !out_valid | out_ready. In FLUSH: in_ready = 0.
- Accept on in_valid & in_ready.
- Output handshake:
  - out_valid & out_ready with no new accept -> out_valid=0; Inst and selects are retained.
  - out_valid & !out_ready -> stage holds Inst, selects and out_valid unchanged.
- Flush:
  - nop=1 in any state has priority over accept and stall.
  - Stage loads NOP_INST decode: Inst=NOP_INST[31:7], ILoad=1, others 0, out_valid=0.
  - State -> FLUSH with counter=FLUSH_HOLD-1.
- FLUSH: counter decrements each cycle. At counter==0 state -> RUN.
- nop re-asserted in FLUSH restarts the counter.
- Simultaneous nop and in_valid: the instruction is dropped (not accepted).
- rst mid-flush: immediate return to reset values.

Optional Feature:
ILLEGAL_DETECT_EN
- Defined:
  - Adds output illegal (1 bit, reset 0).
  - Asserted with the held instruction when the opcode is unlisted and not 0110011/0001111/1110011, or when in_inst[1:0]!=2'b11.
  - Cleared on flush or on next accept.
- Undefined: port absent; unlisted opcodes silently decode to all-zero selects.

Decomposition:
- Shared package imm_pkg:
  - opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL)
  - state encoding (ST_RUN, ST_FLUSH)
  - 5-bit imm-select typedef with bit indices
- Natural sub-module: imm_opcode_decode, a combinational opcode -> one-hot select (+ illegal) decoder, instantiated once.

Test Plan:
- Reset then in_inst=32'h00A00093 (addi), in_valid=1, out_ready=1 -> next cycle out_valid=1, ILoad=1, Inst=25'h0014001.
- Back-to-back sw 32'h00112623 then beq 32'h00208463, out_ready=1 -> consecutive cycles S=1 then SB=1; in_ready stays 1.
- Hold lui 32'h123452B7 with out_ready=0 for 3 cycles -> U=1, Inst stable, in_ready=0 throughout; releases on out_ready=1.
- nop=1 with in_valid=1 (jal 32'h008000EF) -> instruction dropped, out_valid=0, ILoad=1, in_ready=0 exactly FLUSH_HOLD=1 cycle, then jal accepted with UJ=1.
- nop during FLUSH, then rst=1 during a held instruction -> counter restarts; reset forces out_valid=0, all selects 0, state RUN.
- ILLEGAL_DETECT_EN: in_inst=32'h0000007F -> selects all 0, illegal=1; next valid addi -> illegal=0.
